cabin_motion_ctrl: RTL
======================

// Module: cabin_motion_ctrl
// PURPOSE
//   Cabin motion controller sitting directly downstream of the goal-floor selector (goal).
//   Consumes the selected goal floor plus the pending-call lamps, moves the cabin one floor per
//   travel interval and opens the door on arrival. It pulses a clear for the served call lamp.
//   Its floor and moving outputs feed back into goal, closing the loop.
// PARAMETERS
//   LABEL_F1       2'b00  encoding of floor 1; also the reset floor
//   LABEL_F2       2'b01  encoding of floor 2
//   LABEL_F3       2'b10  encoding of floor 3 (2'b11 is an invalid floor code)
//   TRAVEL_CYCLES  8      clock cycles to travel one floor; must be >= 1
//   DOOR_CYCLES    4      clock cycles the door stays open; must be >= 1
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  synchronous reset, active low (sampled on clk)
//   gf         in   2  goal floor from goal
//   led1       in   1  pending call, floor 1
//   led2       in   1  pending call, floor 2
//   led3       in   1  pending call, floor 3
//   floor      out  2  current cabin floor (LABEL_* encoding)
//   moving     out  1  1 while the cabin is travelling between floors
//   dir_up     out  1  travel direction: 1 = up, 0 = down; holds last value when stopped
//   door_open  out  1  1 while the door is open
//   arrived    out  1  one-cycle pulse on the cycle the cabin stops at its target
//   clr_led    out  3  one-cycle clear pulse for the served call; bit0 = F1, bit1 = F2, bit2 = F3
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge), including mid-travel or with the door open:
//     state = IDLE, floor = LABEL_F1, target = LABEL_F1, timer = 0, and all outputs are 0.
//   States:
//   - IDLE. Outputs are quiet. req = led1|led2|led3. On a cycle where req=1 and gf is a valid code:
//     - if gf == floor: go to ARRIVE (target = floor);
//     - otherwise: latch target = gf, set dir_up = (gf > floor), load timer = TRAVEL_CYCLES-1,
//       and go to MOVE.
//     gf = 2'b11 or req = 0: stay in IDLE.
//   - MOVE. moving = 1. The timer decrements every cycle. On the cycle timer == 0, floor steps
//     by one in dir_up at the next edge:
//     - if the new floor == target: go to ARRIVE;
//     - otherwise: reload timer = TRAVEL_CYCLES-1 and stay in MOVE.
//     Net effect: one floor every TRAVEL_CYCLES cycles, first step TRAVEL_CYCLES cycles after
//     entering MOVE.
//   - ARRIVE. Lasts exactly 1 cycle. moving = 0, arrived = 1, clr_led bit of floor = 1.
//     Load timer = DOOR_CYCLES-1 and go to DOOR.
//   - DOOR. door_open = 1 for exactly DOOR_CYCLES cycles, then go to IDLE. New requests are
//     ignored until the cabin is back in IDLE.
//   Invariants and boundary conditions:
//   - target is latched at departure; gf and led changes during MOVE and DOOR are ignored
//     (goal holds gf while moving anyway).
//   - floor saturates: it never steps below LABEL_F1 or above LABEL_F3, and never takes 2'b11.
//     A step that would leave the range forces ARRIVE at the current floor.
//   - At most one clr_led bit is ever set. clr_led and arrived are always coincident.
//   - moving and door_open are never both 1.
//   - Latency: request to door open is 2 cycles when gf == floor, and
//     1 + |floors| * TRAVEL_CYCLES + 1 cycles otherwise.
// STRUCTURE
//   Shared package elevator_pkg:
//     floor label localparams, the 2'b11 invalid code, state enum {IDLE, MOVE, ARRIVE, DOOR}.
//   One sub-module, tick_timer: a loadable down-counter, width $clog2(max(TRAVEL_CYCLES,
//     DOOR_CYCLES)) + 1, with ports load, load_val, zero.
//   Floor step, target compare and one-hot clear decode stay inline in cabin_motion_ctrl.
// TESTING (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
//   1. Reset mid-MOVE (rst_n=0 for 1 edge) -> floor=00, moving=0, door_open=0, clr_led=000;
//      IDLE on the next cycle.
//   2. floor=00, led3=1, gf=10 held 1 cycle -> MOVE, dir_up=1, moving=1 for 8 cycles,
//      floor 00->01->10; then arrived=1 and clr_led=100 for 1 cycle; door_open=1 for 3 cycles;
//      then IDLE.
//   3. floor=01 idle, led2=1, gf=01 -> no motion; next cycle arrived=1, clr_led=010;
//      door_open=1 for 3 cycles.
//   4. floor=10, led1=1, gf=00; gf changed to 01 during MOVE -> cabin still stops at 00,
//      dir_up=0, clr_led=001.
//   5. IDLE, gf=11 with led1=1, or gf=01 with all leds 0 -> state stays IDLE, all outputs 0,
//      floor unchanged.
//   6. Requests asserted while door_open=1 -> ignored until IDLE, then served; assert
//      moving & door_open is never 1 across all tests.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor codes, cabin state enum and timer sizing helper.
package elevator_pkg;

  localparam logic [1:0] FLOOR_F1_CODE = 2'b00;
  localparam logic [1:0] FLOOR_F2_CODE = 2'b01;
  localparam logic [1:0] FLOOR_F3_CODE = 2'b10;
  localparam logic [1:0] FLOOR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    ARRIVE,
    DOOR
  } cabin_state_t;

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return int'($clog2(m)) + 1;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that stops at zero; zero flags the expiry cycle.
module tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cabin_motion_ctrl.sv
// Cabin motion controller: travels one floor per travel interval toward the latched
// target, then arrives (clearing the served call) and holds the door open.
module cabin_motion_ctrl
  import elevator_pkg::*;
#(
  parameter logic [1:0]  LABEL_F1      = FLOOR_F1_CODE,
  parameter logic [1:0]  LABEL_F2      = FLOOR_F2_CODE,
  parameter logic [1:0]  LABEL_F3      = FLOOR_F3_CODE,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gf,
  input  logic       led1,
  input  logic       led2,
  input  logic       led3,
  output logic [1:0] floor,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       arrived,
  output logic [2:0] clr_led
);

  localparam int unsigned TW = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);

  cabin_state_t state, state_nx;
  logic [1:0]    floor_q, floor_nx, target_q, target_nx, step_floor;
  logic          dir_q, dir_nx, at_edge, req, gf_valid;
  logic          tload, tzero;
  logic [TW-1:0] tval;

  tick_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tload),
    .load_val(tval),
    .zero    (tzero)
  );

  assign req      = led1 | led2 | led3;
  assign gf_valid = (gf == LABEL_F1) || (gf == LABEL_F2) || (gf == LABEL_F3);

  // Step by label rather than arithmetic so floor can never reach the invalid code.
  always_comb begin
    if (dir_q) begin
      at_edge    = (floor_q == LABEL_F3);
      step_floor = (floor_q == LABEL_F1) ? LABEL_F2 : LABEL_F3;
    end else begin
      at_edge    = (floor_q == LABEL_F1);
      step_floor = (floor_q == LABEL_F3) ? LABEL_F2 : LABEL_F1;
    end
  end

  always_comb begin
    state_nx  = state;
    floor_nx  = floor_q;
    target_nx = target_q;
    dir_nx    = dir_q;
    tload     = 1'b0;
    tval      = '0;
    moving    = 1'b0;
    door_open = 1'b0;
    arrived   = 1'b0;
    clr_led   = '0;
    unique case (state)
      IDLE: begin
        if (req && gf_valid) begin
          if (gf == floor_q) begin
            target_nx = floor_q;
            state_nx  = ARRIVE;
          end else begin
            target_nx = gf;
            dir_nx    = (gf > floor_q);
            tload     = 1'b1;
            tval      = TW'(TRAVEL_CYCLES - 1);
            state_nx  = MOVE;
          end
        end
      end
      MOVE: begin
        moving = 1'b1;
        if (tzero) begin
          if (at_edge) begin
            target_nx = floor_q;
            state_nx  = ARRIVE;
          end else begin
            floor_nx = step_floor;
            if (step_floor == target_q) begin
              state_nx = ARRIVE;
            end else begin
              tload = 1'b1;
              tval  = TW'(TRAVEL_CYCLES - 1);
            end
          end
        end
      end
      ARRIVE: begin
        arrived    = 1'b1;
        clr_led[0] = (floor_q == LABEL_F1);
        clr_led[1] = (floor_q == LABEL_F2);
        clr_led[2] = (floor_q == LABEL_F3);
        tload      = 1'b1;
        tval       = TW'(DOOR_CYCLES - 1);
        state_nx   = DOOR;
      end
      DOOR: begin
        door_open = 1'b1;
        if (tzero) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      floor_q  <= LABEL_F1;
      target_q <= LABEL_F1;
      dir_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      floor_q  <= floor_nx;
      target_q <= target_nx;
      dir_q    <= dir_nx;
    end
  end

  assign floor  = floor_q;
  assign dir_up = dir_q;

endmodule
